// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the shared-register write arbiter.
//   arb_state_t : FSM state encoding (IDLE / BUSY / DONE). The spare
//                 encoding 2'd3 is illegal and recovers to IDLE.
package reg_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/reg_write_arbiter_rr_select.sv
// rr_select: combinational round-robin picker.
//   req      : per-requester request bits
//   lastId   : index of the previous winner
//   anyReq   : at least one request bit set
//   winnerId : first set req bit searching lastId+1, lastId+2, ... mod NREQ
module rr_select #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  lastId,
  output logic            anyReq,
  output logic [IDW-1:0]  winnerId
);

  int unsigned idx;
  logic        found;

  always_comb begin
    anyReq   = |req;
    winnerId = '0;
    found    = 1'b0;
    idx      = 0;
    // Offset NREQ wraps back to lastId itself, so it is searched last.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(lastId) + k) % NREQ;
      if (!found && req[idx]) begin
        winnerId = idx[IDW-1:0];
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sharing one WIDTH-bit register
// (with synchronous clear) between NREQ requesters.
//   clk        : rising-edge clock
//   asyncReset : asynchronous active-high reset
//   req        : per-requester level write request, held until ack
//   wrData     : flattened write data, requester i at [i*WIDTH +: WIDTH]
//   syncClear  : synchronous clear of the shared register (wins over a write)
//   regQ       : shared register contents
//   ack        : registered one-hot one-cycle write-complete pulse
//   grantId    : index of current/last granted requester
//   busy       : high in BUSY and DONE states
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  asyncReset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wrData,
  input  logic                  syncClear,
  output logic [WIDTH-1:0]      regQ,
  output logic [NREQ-1:0]       ack,
  output logic [IDW-1:0]        grantId,
  output logic                  busy
);

  arb_state_t       state, state_n;
  logic [IDW-1:0]   lastId, lastId_n;
  logic [IDW-1:0]   grantId_n;
  logic [WIDTH-1:0] regQ_n;
  logic [NREQ-1:0]  ack_n;
  logic [WIDTH-1:0] selData;
  logic             anyReq;
  logic [IDW-1:0]   winnerId;

  rr_select #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_select (
    .req      (req),
    .lastId   (lastId),
    .anyReq   (anyReq),
    .winnerId (winnerId)
  );

  // Data of the currently granted requester, sampled at the BUSY edge.
  always_comb begin
    selData = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grantId == IDW'(i)) selData = wrData[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge asyncReset) begin
    if (asyncReset) begin
      state   <= ST_IDLE;
      regQ    <= '0;
      ack     <= '0;
      grantId <= '0;
      lastId  <= IDW'(NREQ - 1);
    end else begin
      state   <= state_n;
      regQ    <= regQ_n;
      ack     <= ack_n;
      grantId <= grantId_n;
      lastId  <= lastId_n;
    end
  end

  always_comb begin
    state_n   = state;
    regQ_n    = regQ;
    ack_n     = '0;
    grantId_n = grantId;
    lastId_n  = lastId;
    case (state)
      ST_IDLE: begin
        if (syncClear) regQ_n = '0;
        if (anyReq) begin
          grantId_n = winnerId;
          state_n   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Clear wins; the write stays pending and retries next cycle.
        if (syncClear) begin
          regQ_n = '0;
        end else begin
          regQ_n         = selData;
          ack_n[grantId] = 1'b1;
          lastId_n       = grantId;
          state_n        = ST_DONE;
        end
      end
      ST_DONE: begin
        if (syncClear) regQ_n = '0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_BUSY) || (state == ST_DONE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        asyncReset;
  logic [3:0]  req;
  logic [31:0] wrData;
  logic        syncClear;
  logic [7:0]  regQ;
  logic [3:0]  ack;
  logic [1:0]  grantId;
  logic        busy;

  int errors = 0;
  int checks = 0;

  reg_write_arbiter #(
    .NREQ  (4),
    .WIDTH (8),
    .IDW   (2)
  ) dut (
    .clk        (clk),
    .asyncReset (asyncReset),
    .req        (req),
    .wrData     (wrData),
    .syncClear  (syncClear),
    .regQ       (regQ),
    .ack        (ack),
    .grantId    (grantId),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    asyncReset = 1'b1;
    req        = '0;
    syncClear  = 1'b0;
    step();
    asyncReset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    asyncReset = 1'b1;
    req = '0; syncClear = 1'b0; wrData = '0;
    #3;
    checks++; if (regQ !== 8'h00) begin errors++; $display("FAIL reset_regQ: got %h expected 00", regQ); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack); end
    checks++; if (grantId !== 2'd0) begin errors++; $display("FAIL reset_grantId: got %0d expected 0", grantId); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    step();
    asyncReset = 1'b0;
    step();
    // Reset mid-transaction.
    wrData[7:0] = 8'h77;
    req = 4'b0001;
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    #2 asyncReset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (regQ !== 8'h00) begin errors++; $display("FAIL midrst_regQ: got %h expected 00", regQ); end
    step();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL midrst_ack: got %b expected 0000", ack); end
    checks++; if (regQ !== 8'h00) begin errors++; $display("FAIL midrst_regQ_hold: got %h expected 00", regQ); end
    req = '0;
    asyncReset = 1'b0;
    step();
  endtask

  task automatic test_priority_after_reset();
    wrData = 32'h44_33_22_11;
    req = 4'b1010;
    step();
    checks++; if (grantId !== 2'd1) begin errors++; $display("FAIL prio_grant1: got %0d expected 1", grantId); end
    step();
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL prio_ack1: got %b expected 0010", ack); end
    checks++; if (regQ !== 8'h22) begin errors++; $display("FAIL prio_regQ1: got %h expected 22", regQ); end
    req = 4'b1000;
    step();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL prio_ack_gap: got %b expected 0000", ack); end
    step();
    checks++; if (grantId !== 2'd3) begin errors++; $display("FAIL prio_grant3: got %0d expected 3", grantId); end
    step();
    checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL prio_ack3: got %b expected 1000", ack); end
    checks++; if (regQ !== 8'h44) begin errors++; $display("FAIL prio_regQ3: got %h expected 44", regQ); end
    req = '0;
    step();
  endtask

  task automatic test_single_write();
    wrData = 32'h00_A5_00_00;
    req = 4'b0100;
    step();
    checks++; if (grantId !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d expected 2", grantId); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_early: got %b expected 0000", ack); end
    step();
    checks++; if (regQ !== 8'hA5) begin errors++; $display("FAIL single_regQ: got %h expected a5", regQ); end
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_done: got %b expected 1", busy); end
    req = '0;
    step();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse: got %b expected 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
    checks++; if (grantId !== 2'd2) begin errors++; $display("FAIL single_grant_hold: got %0d expected 2", grantId); end
  endtask

  task automatic test_fairness();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_ack;
    logic [7:0] exp_q;
    do_reset();
    wrData = 32'h13_12_11_10;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_ack = 4'b0001 << order[k];
      exp_q   = 8'h10 + 8'(order[k]);
      step();
      checks++; if (grantId !== 2'(order[k])) begin errors++; $display("FAIL fair_grant[%0d]: got %0d expected %0d", k, grantId, order[k]); end
      step();
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL fair_ack[%0d]: got %b expected %b", k, ack, exp_ack); end
      checks++; if (regQ !== exp_q) begin errors++; $display("FAIL fair_regQ[%0d]: got %h expected %h", k, regQ, exp_q); end
      req[order[k]] = 1'b0;
      step();
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL fair_gap[%0d]: got %b expected 0000", k, ack); end
      req[order[k]] = 1'b1;
    end
    req = '0;
    step();
  endtask

  task automatic test_clear_collision();
    wrData = 32'h00_00_00_FF;
    req = 4'b0001;
    step(); step();
    req = '0;
    step();
    checks++; if (regQ !== 8'hFF) begin errors++; $display("FAIL coll_prior: got %h expected ff", regQ); end
    wrData = 32'h00_00_00_3C;
    req = 4'b0001;
    step();
    syncClear = 1'b1;
    step();
    checks++; if (regQ !== 8'h00) begin errors++; $display("FAIL coll_regQ_clr: got %h expected 00", regQ); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL coll_ack_none: got %b expected 0000", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL coll_busy: got %b expected 1", busy); end
    syncClear = 1'b0;
    step();
    checks++; if (regQ !== 8'h3C) begin errors++; $display("FAIL coll_regQ_retry: got %h expected 3c", regQ); end
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL coll_ack_retry: got %b expected 0001", ack); end
    req = '0;
    step();
  endtask

  task automatic test_clear_idle();
    wrData = 32'h00_00_55_00;
    req = 4'b0010;
    step(); step();
    req = '0;
    step();
    checks++; if (regQ !== 8'h55) begin errors++; $display("FAIL idle_prior: got %h expected 55", regQ); end
    syncClear = 1'b1;
    step();
    syncClear = 1'b0;
    checks++; if (regQ !== 8'h00) begin errors++; $display("FAIL idle_clr_regQ: got %h expected 00", regQ); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_clr_busy: got %b expected 0", busy); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL idle_clr_ack: got %b expected 0000", ack); end
    step();
    checks++; if (grantId !== 2'd1) begin errors++; $display("FAIL idle_grant_hold: got %0d expected 1", grantId); end
  endtask

  initial begin
    test_reset();
    test_priority_after_reset();
    test_single_write();
    test_fairness();
    test_clear_collision();
    test_clear_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
